test_collector: RTL
===================

# test_collector

Parametrised, synthesizable test-result collector that sequences a bank of `NUM_TESTS` self-checking test instances. It drives their shared test reset, latches per-test `fail`/`finish` flags, and reports one registered verdict. An optional watchdog bounds the run. It replaces the hand-written top-level fail/finish reduction: the bus widths track `NUM_TESTS`, the first failing test is identified, and the run is bounded by a timeout.

## Interface
- `NUM_TESTS`, 43, number of test instances (≥1).
- `RESET_CYCLES`, 16, cycles `test_reset` is held after `start` rises (≥1).
- `CYCLE_W`, 32, width of the run-cycle counter.
- `TIMEOUT`, 100000, run-cycle limit; only used with `TEST_COLLECTOR_TIMEOUT_EN`.
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level request; a rising level begins a run, and dropping it aborts or releases.
- `fail`  in  NUM_TESTS  per-test fail flag; may pulse.
- `finish`  in  NUM_TESTS  per-test finish flag; may pulse.
- `test_reset`  out  1  active-high reset to all tests.
- `done`  out  1  verdict valid.
- `pass`  out  1  all tests finished and none failed.
- `timeout`  out  1  run ended by the watchdog.
- `fail_index`  out  IDX_W=max(1,$clog2(NUM_TESTS))  lowest failing index in the first failing cycle.
- `fail_count`  out  CNT_W=$clog2(NUM_TESTS+1)  number of tests whose fail flag is latched.
- `finish_count`  out  CNT_W  number of tests whose finish flag is latched.
- `cycle_count`  out  CYCLE_W  RUN cycles elapsed; saturates at all-ones.

## Operation
- FSM has four states: IDLE, HOLD, RUN and DONE. All outputs are registered.
- Reset values (`reset_n`=0): state=IDLE, `test_reset`=1, `done`=0, `pass`=0, `timeout`=0, `fail_index`=0, all counts 0, and the sticky vectors are 0.
- **IDLE**: `test_reset`=1. When `start`=1, go to HOLD and load the hold counter with RESET_CYCLES-1.
- **HOLD**: `test_reset`=1. The hold counter decrements each cycle.
  - On the cycle the counter is 0, go to RUN. Clear the sticky vectors, the counts, `cycle_count`, `done`, `pass`, `timeout` and `fail_index`.
- **RUN**: `test_reset`=0. Each cycle: `fail_seen |= fail`, `finish_seen |= finish`, and `cycle_count` increments.
  - `fail_count` is the popcount of `fail_seen`; `finish_count` is the popcount of `finish_seen`.
- **RUN exit priority**, highest first, when several conditions occur in the same cycle:
  - Fail: the next `fail_seen` is non-zero. Go to DONE with `pass`=0. `fail_index` is the lowest set bit of `fail & ~fail_seen` in that cycle.
  - Timeout: the next `cycle_count` equals TIMEOUT. Go to DONE with `timeout`=1 and `pass`=0.
  - All finished: the next `finish_seen` is all-ones. Go to DONE with `pass`=1.
- **DONE**: `done`=1 and `test_reset`=0. The verdict and counts freeze, and inputs are ignored. When `start`=0, go to IDLE; the status outputs are retained until the next HOLD.
- `start`=0 during HOLD or RUN aborts to IDLE with `done`=0.
- `fail`/`finish` inputs are ignored outside RUN.
- Asserting `reset_n` at any time returns to the reset values immediately.

## Timing
- From the `start` rise being sampled to the first RUN cycle (`test_reset`=0) is RESET_CYCLES+1 cycles.
- An event sampled at RUN edge k produces `done`=1 from edge k+1 (latency 1).
- `cycle_count` on exit equals the number of RUN cycles sampled, including the exit cycle.
- `done` stays high for as long as `start` stays high, and drops one cycle after `start` falls.

## Configuration
- `TEST_COLLECTOR_TIMEOUT_EN` defined: the watchdog is compiled in and the timeout exit applies.
- Macro undefined: no comparator is built and `timeout` is tied to 0. A run that never fails or finishes stays in RUN indefinitely, and `cycle_count` saturates.

## Structure
- `test_collector_pkg` holds the state enum (IDLE/HOLD/RUN/DONE) and the `clog2`-based width helper functions.
- One sub-module, `test_first_index`, is a parametrised combinational lowest-set-bit priority encoder that also outputs a valid bit. It produces `fail_index`.
- The popcounts are functions in the package.

## Test plan
All scenarios use NUM_TESTS=4, RESET_CYCLES=2, TIMEOUT=20 with the macro defined, unless noted.
- **All pass:** raise `start`, then pulse `finish`=0001, 0110 and 1000 on RUN cycles 1, 3 and 5 → `done`=1 with `pass`=1, `finish_count`=4, `fail_count`=0 and `cycle_count`=5.
- **Simultaneous fail and finish:** `finish`=1111 and `fail`=0100 in the same RUN cycle → `pass`=0 and `fail_index`=2.
- **Multiple first failures:** `fail`=1010 first asserted together → `fail_index`=1 and `fail_count`=2.
- **Timeout:** no flags for 20 RUN cycles → `timeout`=1 and `pass`=0 with `cycle_count`=20.
- **Timeout compiled out:** same stimulus with the macro undefined → `done` stays 0 after 100 cycles.
- **Abort and reset:** drop `start` mid-RUN → IDLE with `test_reset`=1 and `done`=0. Pulse `reset_n` low while in DONE → all outputs return to reset values on the same edge.

Source files
------------

// File: rtl/test_collector_pkg.sv
// ---------------------------------------------------------------------------
// test_collector_pkg : FSM state type, width helpers and popcount for the
//                      test-result collector.            Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package test_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Upper bound on the test bank; the popcount works on a zero-extended vector.
  localparam int MAX_TESTS = 1024;
  localparam int POP_W     = 11;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_TESTS-1:0] v);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_TESTS; i++) begin
      cnt = cnt + POP_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/test_first_index.sv
// ---------------------------------------------------------------------------
// test_first_index : lowest-set-bit priority encoder with valid flag.
//                    Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module test_first_index #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign valid_o = |vec_i;

endmodule

`default_nettype wire

// File: rtl/test_collector.sv
// ---------------------------------------------------------------------------
// test_collector : sequences a bank of self-checking tests and reports one
//                  registered verdict. Watchdog: TEST_COLLECTOR_TIMEOUT_EN.
//                  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module test_collector
  import test_collector_pkg::*;
#(
  parameter int NUM_TESTS    = 43,
  parameter int RESET_CYCLES = 16,
  parameter int CYCLE_W      = 32,
  parameter int TIMEOUT      = 100000
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [NUM_TESTS-1:0]          fail,
  input  logic [NUM_TESTS-1:0]          finish,
  output logic                          test_reset,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
  output logic [idx_w(NUM_TESTS)-1:0]   fail_index,
  output logic [cnt_w(NUM_TESTS)-1:0]   fail_count,
  output logic [cnt_w(NUM_TESTS)-1:0]   finish_count,
  output logic [CYCLE_W-1:0]            cycle_count
);

  localparam int IDX_W  = idx_w(NUM_TESTS);
  localparam int CNT_W  = cnt_w(NUM_TESTS);
  localparam int HOLD_W = idx_w(RESET_CYCLES);

  state_e               state_q;
  logic [HOLD_W-1:0]    hold_q;
  logic [NUM_TESTS-1:0] fail_seen_q, finish_seen_q;
  logic [CYCLE_W-1:0]   cycle_q;
  logic [IDX_W-1:0]     fail_index_q;
  logic [CNT_W-1:0]     fail_count_q, finish_count_q;
  logic                 test_reset_q, done_q, pass_q, timeout_q;

  logic [NUM_TESTS-1:0] fail_seen_d, finish_seen_d, new_fail;
  logic [CYCLE_W-1:0]   cycle_d;
  logic [CNT_W-1:0]     fail_count_d, finish_count_d;
  logic [IDX_W-1:0]     first_idx;
  logic                 first_valid, fail_exit, timeout_hit;

  assign fail_seen_d    = fail_seen_q | fail;
  assign finish_seen_d  = finish_seen_q | finish;
  assign new_fail       = fail & ~fail_seen_q;
  assign cycle_d        = (&cycle_q) ? cycle_q : cycle_q + 1'b1;
  assign fail_count_d   = CNT_W'(popcount(MAX_TESTS'(fail_seen_d)));
  assign finish_count_d = CNT_W'(popcount(MAX_TESTS'(finish_seen_d)));
  assign fail_exit      = first_valid | (|fail_seen_q);

`ifdef TEST_COLLECTOR_TIMEOUT_EN
  assign timeout_hit = (cycle_d == CYCLE_W'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  test_first_index #(
    .N     (NUM_TESTS),
    .IDX_W (IDX_W)
  ) u_first_index (
    .vec_i   (new_fail),
    .idx_o   (first_idx),
    .valid_o (first_valid)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      hold_q         <= '0;
      fail_seen_q    <= '0;
      finish_seen_q  <= '0;
      cycle_q        <= '0;
      fail_index_q   <= '0;
      fail_count_q   <= '0;
      finish_count_q <= '0;
      test_reset_q   <= 1'b1;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          test_reset_q <= 1'b1;
          if (start) begin
            state_q <= ST_HOLD;
            hold_q  <= HOLD_W'(RESET_CYCLES - 1);
          end
        end
        ST_HOLD: begin
          if (!start) begin
            state_q      <= ST_IDLE;
            test_reset_q <= 1'b1;
            done_q       <= 1'b0;
          end else if (hold_q == '0) begin
            state_q        <= ST_RUN;
            test_reset_q   <= 1'b0;
            fail_seen_q    <= '0;
            finish_seen_q  <= '0;
            cycle_q        <= '0;
            fail_index_q   <= '0;
            fail_count_q   <= '0;
            finish_count_q <= '0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            timeout_q      <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        ST_RUN: begin
          if (!start) begin
            state_q      <= ST_IDLE;
            test_reset_q <= 1'b1;
            done_q       <= 1'b0;
          end else begin
            fail_seen_q    <= fail_seen_d;
            finish_seen_q  <= finish_seen_d;
            cycle_q        <= cycle_d;
            fail_count_q   <= fail_count_d;
            finish_count_q <= finish_count_d;
            // Exit priority: fail, then watchdog, then all-finished.
            if (fail_exit) begin
              state_q      <= ST_DONE;
              done_q       <= 1'b1;
              pass_q       <= 1'b0;
              fail_index_q <= first_idx;
            end else if (timeout_hit) begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              pass_q    <= 1'b0;
              timeout_q <= 1'b1;
            end else if (&finish_seen_d) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          test_reset_q <= 1'b0;
          if (!start) begin
            state_q      <= ST_IDLE;
            test_reset_q <= 1'b1;
            done_q       <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign test_reset   = test_reset_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign fail_index   = fail_index_q;
  assign fail_count   = fail_count_q;
  assign finish_count = finish_count_q;
  assign cycle_count  = cycle_q;

endmodule

`default_nettype wire
